// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, minimum divisor and default frame width.
package uart_pkg;

    localparam int UART_MIN_DIV    = 4;
    localparam int UART_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable reset level.
module uart_sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_r;
    logic sync_r;

    // Metastability chain; both stages come out of reset at the line's idle level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_r <= RESET_VALUE;
            sync_r <= RESET_VALUE;
        end else begin
            meta_r <= d_i;
            sync_r <= meta_r;
        end
    end

    assign q_o = sync_r;

endmodule

// File: rtl/uart_rx_core.sv
// UART 8N1 receive stage: start detection, mid-bit sampling and result strobes toward the rx buffer.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic [DIV_WIDTH-1:0]  clks_per_bit_i,
    input  logic                  rx_i,
    input  logic                  buffer_full_i,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  we_o,
    output logic                  frame_err_o,
    output logic                  overrun_o,
    output logic                  break_o,
    output logic                  busy_o
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0]        LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [DIV_WIDTH-1:0] MIN_DIV  = DIV_WIDTH'(UART_MIN_DIV);
    localparam logic [DIV_WIDTH-1:0] ONE      = DIV_WIDTH'(1);

    rx_state_e             state_r, next_state_s;
    logic                  rx_s, rx_q_r, fall_s;
    logic [DIV_WIDTH-1:0]  div_s, half_s, cnt_r;
    logic [BW-1:0]         bit_cnt_r;
    logic [DATA_WIDTH-1:0] shift_r, wdata_r;
    logic                  tick_s, stop_tick_s;
    logic                  we_s, fe_s, ovr_s, brk_s;
    logic                  we_r, fe_r, ovr_r, brk_r, busy_r;

    uart_sync_2ff #(.RESET_VALUE(1'b1)) u_rx_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (rx_i),
        .q_o    (rx_s)
    );

    assign div_s  = (clks_per_bit_i < MIN_DIV) ? MIN_DIV : clks_per_bit_i;
    assign half_s = div_s >> 1;
    assign fall_s = rx_q_r & ~rx_s;

    // Delayed copy of the synchronised line for falling-edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rx_q_r <= 1'b1;
        else         rx_q_r <= rx_s;
    end

    // Sample-point decode: START counts to the half bit, later bits to a full period.
    always_comb begin
        tick_s = 1'b0;
        case (state_r)
            START:      tick_s = (cnt_r == half_s - ONE);
            DATA, STOP: tick_s = (cnt_r == div_s - ONE);
            default:    tick_s = 1'b0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_r <= IDLE;
        else         state_r <= next_state_s;
    end

    // FSM next-state logic; a disabled receiver always falls back to IDLE.
    always_comb begin
        next_state_s = state_r;
        if (!en_i) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    next_state_s = fall_s ? START : IDLE;
                START:   next_state_s = tick_s ? (rx_s ? IDLE : DATA) : START;
                DATA:    next_state_s = (tick_s && bit_cnt_r == LAST_BIT) ? STOP : DATA;
                STOP:    next_state_s = tick_s ? IDLE : STOP;
                default: next_state_s = IDLE;
            endcase
        end
    end

    // FSM output decode: classify the stop sample into exactly one result.
    always_comb begin
        stop_tick_s = en_i & tick_s & (state_r == STOP);
        we_s  = 1'b0;
        fe_s  = 1'b0;
        ovr_s = 1'b0;
        brk_s = 1'b0;
        if (stop_tick_s) begin
            we_s  =  rx_s & ~buffer_full_i;
            ovr_s =  rx_s &  buffer_full_i;
            brk_s = ~rx_s & (shift_r == '0);
            fe_s  = ~rx_s & (shift_r != '0);
        end else begin
            we_s  = 1'b0;
        end
    end

    // Bit-period counter, data-bit counter and LSB-first shift register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r     <= '0;
            bit_cnt_r <= '0;
            shift_r   <= '0;
        end else if (!en_i || state_r == IDLE) begin
            cnt_r     <= '0;
            bit_cnt_r <= '0;
        end else if (tick_s) begin
            cnt_r <= '0;
            if (state_r == DATA) begin
                shift_r   <= {rx_s, shift_r[DATA_WIDTH-1:1]};
                bit_cnt_r <= bit_cnt_r + BW'(1);
            end
        end else begin
            cnt_r <= cnt_r + ONE;
        end
    end

    // Registered result pulses, held byte and busy flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_r    <= 1'b0;
            fe_r    <= 1'b0;
            ovr_r   <= 1'b0;
            brk_r   <= 1'b0;
            busy_r  <= 1'b0;
            wdata_r <= '0;
        end else begin
            we_r   <= we_s;
            fe_r   <= fe_s;
            ovr_r  <= ovr_s;
            brk_r  <= brk_s;
            busy_r <= (next_state_s != IDLE);
            if (we_s) wdata_r <= shift_r;
        end
    end

    assign wdata_o     = wdata_r;
    assign we_o        = we_r;
    assign frame_err_o = fe_r;
    assign overrun_o   = ovr_r;
    assign break_o     = brk_r;
    assign busy_o      = busy_r;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: timing, framing, break, overrun, abort, reset and divisor clamp.
module tb_uart_rx_core;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        en_i;
    logic [15:0] clks_per_bit_i;
    logic        rx_i;
    logic        buffer_full_i;
    logic [7:0]  wdata_o;
    logic        we_o, frame_err_o, overrun_o, break_o, busy_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_cnt = 0, fe_cnt = 0, ovr_cnt = 0, brk_cnt = 0, multi_cnt = 0;
    int last_we_cyc = 0;
    logic [7:0] byte_log [64];

    uart_rx_core #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .en_i           (en_i),
        .clks_per_bit_i (clks_per_bit_i),
        .rx_i           (rx_i),
        .buffer_full_i  (buffer_full_i),
        .wdata_o        (wdata_o),
        .we_o           (we_o),
        .frame_err_o    (frame_err_o),
        .overrun_o      (overrun_o),
        .break_o        (break_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Pulse monitor sampled on the falling edge.
    always @(negedge clk_i) begin
        if (we_o) begin
            if (we_cnt < 64) byte_log[we_cnt] = wdata_o;
            we_cnt      = we_cnt + 1;
            last_we_cyc = cyc;
        end
        if (frame_err_o) fe_cnt = fe_cnt + 1;
        if (overrun_o)   ovr_cnt = ovr_cnt + 1;
        if (break_o)     brk_cnt = brk_cnt + 1;
        if (32'(we_o) + 32'(frame_err_o) + 32'(overrun_o) + 32'(break_o) > 32'd1)
            multi_cnt = multi_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int n);
        rx_i = b;
        repeat (n) @(negedge clk_i);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int n);
        send_bit(1'b0, n);
        for (int i = 0; i < 8; i++) send_bit(d[i], n);
        send_bit(stop, n);
    endtask

    function automatic int total_pulses();
        return we_cnt + fe_cnt + ovr_cnt + brk_cnt;
    endfunction

    initial begin
        int t0, w0, p0, f0, b0, o0;
        rst_ni = 1'b0; en_i = 1'b1; rx_i = 1'b1; buffer_full_i = 1'b0;
        clks_per_bit_i = 16'd16;
        repeat (3) @(negedge clk_i);
        check_eq("rst_wdata", 32'(wdata_o), 32'h0);
        check_eq("rst_we",    32'(we_o),    32'h0);
        check_eq("rst_fe",    32'(frame_err_o), 32'h0);
        check_eq("rst_ovr",   32'(overrun_o),   32'h0);
        check_eq("rst_brk",   32'(break_o),     32'h0);
        check_eq("rst_busy",  32'(busy_o),      32'h0);
        rst_ni = 1'b1;
        send_bit(1'b1, 5);

        // Single byte latency: stop sample at 8+9*16, pulse one later, plus 2 sync cycles.
        t0 = cyc; w0 = we_cnt;
        send_frame(8'hA5, 1'b1, 16);
        send_bit(1'b1, 10);
        check_eq("single_cnt",  32'(we_cnt - w0), 32'd1);
        check_eq("single_lat",  32'(last_we_cyc - t0), 32'd155);
        check_eq("single_data", 32'(wdata_o), 32'hA5);

        // Back-to-back frames with no idle gap.
        w0 = we_cnt;
        send_frame(8'h00, 1'b1, 16);
        send_frame(8'hFF, 1'b1, 16);
        send_frame(8'h3C, 1'b1, 16);
        send_bit(1'b1, 20);
        check_eq("b2b_cnt", 32'(we_cnt - w0), 32'd3);
        check_eq("b2b_b0", 32'(byte_log[w0 % 64]),       32'h00);
        check_eq("b2b_b1", 32'(byte_log[(w0 + 1) % 64]), 32'hFF);
        check_eq("b2b_b2", 32'(byte_log[(w0 + 2) % 64]), 32'h3C);

        // Glitch: 5 low cycles, start sample at cycle 8 sees high.
        p0 = total_pulses();
        rx_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check_eq("glitch_busy_c0", 32'(busy_o), 32'h0);
        @(negedge clk_i);
        check_eq("glitch_busy_c1", 32'(busy_o), 32'h1);
        repeat (2) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (6) @(negedge clk_i);
        check_eq("glitch_busy_c9", 32'(busy_o), 32'h0);
        send_bit(1'b1, 200);
        check_eq("glitch_pulses", 32'(total_pulses() - p0), 32'd0);

        // Framing error.
        w0 = we_cnt; f0 = fe_cnt;
        send_frame(8'h55, 1'b0, 16);
        send_bit(1'b1, 20);
        check_eq("fe_cnt", 32'(fe_cnt - f0), 32'd1);
        check_eq("fe_no_we", 32'(we_cnt - w0), 32'd0);

        // Break: line low for 12 bit times.
        w0 = we_cnt; f0 = fe_cnt; b0 = brk_cnt;
        send_bit(1'b0, 12 * 16);
        send_bit(1'b1, 40);
        check_eq("brk_cnt", 32'(brk_cnt - b0), 32'd1);
        check_eq("brk_no_we", 32'(we_cnt - w0), 32'd0);
        check_eq("brk_no_fe", 32'(fe_cnt - f0), 32'd0);

        // Overrun, then recovery once the buffer drains.
        w0 = we_cnt; o0 = ovr_cnt;
        buffer_full_i = 1'b1;
        send_frame(8'h12, 1'b1, 16);
        buffer_full_i = 1'b0;
        send_bit(1'b1, 10);
        check_eq("ovr_cnt", 32'(ovr_cnt - o0), 32'd1);
        check_eq("ovr_no_we", 32'(we_cnt - w0), 32'd0);
        send_frame(8'h34, 1'b1, 16);
        send_bit(1'b1, 20);
        check_eq("ovr_next_we", 32'(we_cnt - w0), 32'd1);
        check_eq("ovr_next_data", 32'(wdata_o), 32'h34);

        // Enable dropped after four data bits.
        p0 = total_pulses();
        send_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 16);
        en_i = 1'b0;
        send_bit(1'b1, 2);
        check_eq("abort_busy", 32'(busy_o), 32'h0);
        send_bit(1'b1, 20);
        en_i = 1'b1;
        send_bit(1'b1, 200);
        check_eq("abort_pulses", 32'(total_pulses() - p0), 32'd0);
        w0 = we_cnt;
        send_frame(8'h5A, 1'b1, 16);
        send_bit(1'b1, 20);
        check_eq("abort_next_we", 32'(we_cnt - w0), 32'd1);
        check_eq("abort_next_data", 32'(wdata_o), 32'h5A);

        // Reset mid-frame clears everything at once.
        p0 = total_pulses();
        send_bit(1'b0, 16);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 16);
        rst_ni = 1'b0;
        #1;
        check_eq("midrst_wdata", 32'(wdata_o), 32'h0);
        check_eq("midrst_busy",  32'(busy_o),  32'h0);
        check_eq("midrst_we",    32'(we_o),    32'h0);
        rx_i = 1'b1;
        @(negedge clk_i);
        rst_ni = 1'b1;
        send_bit(1'b1, 200);
        check_eq("midrst_pulses", 32'(total_pulses() - p0), 32'd0);

        // Divisor below the minimum clamps to 4: latency 2+9*4+1+2.
        clks_per_bit_i = 16'd2;
        send_bit(1'b1, 10);
        t0 = cyc; w0 = we_cnt;
        send_frame(8'hC3, 1'b1, 4);
        send_bit(1'b1, 20);
        check_eq("clamp_cnt",  32'(we_cnt - w0), 32'd1);
        check_eq("clamp_lat",  32'(last_we_cyc - t0), 32'd41);
        check_eq("clamp_data", 32'(wdata_o), 32'hC3);

        check_eq("exclusive_pulses", 32'(multi_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial-to-parallel UART receive stage. Synchronises the asynchronous `rx_i` line, detects start bits, samples 8N1 frames at mid-bit using a programmable clock divisor, and pushes each good byte into the downstream receive buffer with a single-cycle write strobe. Owns framing-error, overrun and break detection; the buffer only stores bytes.

## Interface
- `DATA_WIDTH`, 8: frame data bits, LSB first.
- `DIV_WIDTH`, 16: width of the bit-period divisor.
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `en_i`  in  1  receiver enable; low forces IDLE.
- `clks_per_bit_i`  in  DIV_WIDTH  clk_i cycles per bit; must be static while a frame is in progress.
- `rx_i`  in  1  asynchronous serial line, idle high.
- `buffer_full_i`  in  1  downstream buffer full.
- `wdata_o`  out  DATA_WIDTH  received byte, valid when `we_o`=1.
- `we_o`  out  1  one-cycle write strobe to buffer.
- `frame_err_o`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun_o`  out  1  one-cycle pulse: good byte dropped because buffer full.
- `break_o`  out  1  one-cycle pulse: all data bits and stop bit sampled 0.
- `busy_o`  out  1  high in any state other than IDLE.

## Operation
- `rx_i` passes through a 2-flop synchroniser, both flops reset to 1; all logic below uses the synchronised value `rx_s`, including a registered copy `rx_q` for edge detection.
- Effective divisor `div` = max(`clks_per_bit_i`, 4); values below 4 clamp to 4.
- States: IDLE, START, DATA, STOP.
- IDLE: on `en_i`=1 and `rx_q`=1 & `rx_s`=0 (falling edge), go to START with bit counter cleared.
- START: at cycle `div/2` after the edge (integer division), sample `rx_s`. If it is 0, go to DATA. If it is 1, treat it as a false start and return to IDLE with no outputs.
- DATA: sample every `div` cycles into a shift register, LSB first. After `DATA_WIDTH` samples, go to STOP.
- STOP: sample `div` cycles after the last data bit, then return to IDLE in the same cycle. The next start edge is accepted on the following cycle.
- Result of the stop sample:
  - stop=1, `buffer_full_i`=0: `we_o`=1 and `wdata_o`=byte.
  - stop=1, `buffer_full_i`=1: `overrun_o`=1; no write.
  - stop=0 and byte=0: `break_o`=1; no write.
  - stop=0 and byte≠0: `frame_err_o`=1; no write.
- Overrun decision uses `buffer_full_i` as sampled in the stop-sample cycle.
- `en_i` low in any state: go to IDLE next cycle. The partial frame is discarded and no strobe is issued.
- Bit-period counter is DIV_WIDTH bits and resets to 0 at each sample point; it never wraps within a bit.

## Timing
- Reset values: state IDLE; `wdata_o`=0; `we_o`, `frame_err_o`, `overrun_o`, `break_o`, `busy_o` all 0; synchroniser flops 1.
- Cycle 0 is the first cycle `rx_s`=0. Cycle 0 is 2 cycles after the `rx_i` transition.
- Sample points: cycle `div/2 + k*div`, where k=0 is start, k=1..8 are data, k=9 is stop.
- All four result pulses are registered: high for exactly one cycle, at sample cycle + 1.
- `wdata_o` holds its last value until the next strobe.
- `busy_o` is registered and rises at cycle 1.
- At most one of `we_o`, `frame_err_o`, `overrun_o`, `break_o` is high in any cycle.
- Reset asserted mid-frame returns everything to reset values immediately; no strobe is issued.

## Structure
- Shared `uart_pkg` holds:
  - `rx_state_e` enum (IDLE/START/DATA/STOP).
  - `UART_MIN_DIV` = 4.
  - Default `DATA_WIDTH`.
- Sub-module `uart_sync_2ff`: parameterised reset value, reusable by the TX side for CTS.
- FSM, bit-period counter and shift register stay in `uart_rx_core`.

## Test plan
- Single byte, `clks_per_bit_i`=16, send 0xA5 with stop=1 → `we_o` pulses once at 155 cycles after the `rx_i` falling edge, `wdata_o`=0xA5.
- Back-to-back frames 0x00, 0xFF, 0x3C with no idle gap → exactly three strobes with correct bytes.
- Glitch: `rx_i` low for 5 cycles with div=16 → false start; no pulses; `busy_o` returns to 0 by cycle 9.
- Framing and break:
  - 0x55 with stop=0 → `frame_err_o` pulse, no `we_o`.
  - Line held low for 12 bit times → one `break_o` pulse.
- `buffer_full_i`=1 during the stop sample of 0x12 → `overrun_o` pulse, no `we_o`; the next byte 0x34 is written after full clears.
- Abort and clamp:
  - `en_i` dropped at bit 4 → no strobe; a new frame afterwards is received correctly.
  - `rst_ni` pulsed mid-frame → all outputs 0.
  - `clks_per_bit_i`=2 → behaves as div=4.
